// File: rtl/seg7_reader.sv
// seg7_reader: glitch-filtered readback of an active-low 7-segment priority-encoder display
module seg7_reader #(
    parameter int STABLE = 4
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [6:0] seg_n,
    input  logic       hold,
    output logic [3:0] digit,
    output logic [2:0] y,
    output logic       z,
    output logic       act,
    output logic       err,
    output logic       upd,
    output logic [7:0] chg_cnt
);
    localparam logic [7:0] STB = 8'(STABLE);
    localparam logic [6:0] BLANK = 7'b1111111;
    logic [6:0] s1, s2, pend, cur;
    logic [7:0] cnt, cnt_nx;
    logic       commit;
    logic [9:0] dec;
    // commit on the edge where the count reaches STABLE, so input-to-output latency is STABLE+2
    always_comb begin
        cnt_nx = (s2 != pend) ? 8'd1 : (!hold && cnt < STB) ? cnt + 8'd1 : cnt;
        commit = (cnt_nx == STB) && !hold && (s2 != cur);
        case (s2)
            7'b0000001: dec = {4'd0, 3'd0, 3'b010};
            7'b1001111: dec = {4'd1, 3'd0, 3'b110};
            7'b0010010: dec = {4'd2, 3'd1, 3'b110};
            7'b0000110: dec = {4'd3, 3'd2, 3'b110};
            7'b1001100: dec = {4'd4, 3'd3, 3'b110};
            7'b0100100: dec = {4'd5, 3'd4, 3'b110};
            7'b1100000: dec = {4'd6, 3'd5, 3'b110};
            7'b0001111: dec = {4'd7, 3'd6, 3'b110};
            7'b0000000: dec = {4'd8, 3'd7, 3'b110};
            7'b0001100: dec = {4'd9, 3'd0, 3'b011};
            BLANK:      dec = {4'd0, 3'd0, 3'b000};
            default:    dec = {4'd0, 3'd0, 3'b011};
        endcase
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1 <= BLANK;
            s2 <= BLANK;
            pend <= BLANK;
            cur <= BLANK;
            cnt <= 8'd0;
            {digit, y, z, act, err} <= 10'd0;
            upd <= 1'b0;
            chg_cnt <= 8'd0;
        end else begin
            s1 <= seg_n;
            s2 <= s1;
            pend <= s2;
            cnt <= cnt_nx;
            upd <= commit;
            if (commit) begin
                cur <= s2;
                {digit, y, z, act, err} <= dec;
                chg_cnt <= chg_cnt + 8'd1;
            end
        end
    end
endmodule
